// File: rtl/fpacc_pkg.sv
// Shared types, constants and helpers for the floating-point accumulator controller.
package fpacc_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [7:0]  FP_EXP_ZERO       = 8'h00;
  localparam logic [30:0] FP_MAX_FINITE_MAG = 31'h7F7FFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  // Running frame payload: value plus sticky exception flags.
  typedef struct packed {
    logic [FP_W-1:0] sum;
    logic            overflow;
    logic            underflow;
  } acc_s;

  function automatic logic is_zero_class(input logic [FP_W-1:0] v);
    return v[30:23] == FP_EXP_ZERO;
  endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational IEEE754 single add/sub stage: truncating alignment, implicit leading one,
// larger operand passed through when the exponent gap exceeds the mantissa width.
module add_sub (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        checkequation,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic        a_big;
  logic        sign_l;
  logic        sign_s;
  logic [7:0]  exp_l;
  logic [7:0]  exp_s;
  logic [7:0]  diff;
  logic [23:0] man_l;
  logic [23:0] man_s;
  logic [23:0] man_al;
  logic [24:0] sum;
  logic [23:0] dif;
  logic [4:0]  lz;
  logic [22:0] norm;
  logic [8:0]  exp_n;

  function automatic logic [4:0] lzc(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  always_comb begin
    a_big   = A[30:0] >= B[30:0];
    sign_l  = a_big ? A[31] : (B[31] ^ checkequation);
    sign_s  = a_big ? (B[31] ^ checkequation) : A[31];
    exp_l   = a_big ? A[30:23] : B[30:23];
    exp_s   = a_big ? B[30:23] : A[30:23];
    man_l   = a_big ? {1'b1, A[22:0]} : {1'b1, B[22:0]};
    man_s   = a_big ? {1'b1, B[22:0]} : {1'b1, A[22:0]};
    diff    = exp_l - exp_s;
    man_al  = man_s >> diff;
    sum     = {1'b0, man_l} + {1'b0, man_al};
    dif     = man_l - man_al;
    lz      = lzc(dif);
    norm    = 23'(dif << lz);
    exp_n   = {1'b0, exp_l} + 9'd1;
    result    = {sign_l, exp_l, man_l[22:0]};
    overflow  = 1'b0;
    underflow = 1'b0;

    if (diff > 8'd24) begin
      result = {sign_l, exp_l, man_l[22:0]};
    end else if (sign_l == sign_s) begin
      if (sum[24]) begin
        if (exp_n >= 9'd255) begin
          overflow = 1'b1;
          result   = {sign_l, 8'hFF, 23'h0};
        end else begin
          result = {sign_l, exp_n[7:0], sum[23:1]};
        end
      end else begin
        result = {sign_l, exp_l, sum[22:0]};
      end
    end else if (dif == 24'd0) begin
      result = 32'h0;
    end else if ({1'b0, exp_l} <= {4'b0, lz}) begin
      underflow = 1'b1;
      result    = {sign_l, 31'h0};
    end else begin
      result = {sign_l, exp_l - {3'b0, lz}, norm};
    end
  end

endmodule

// File: rtl/fp_classify.sv
// Operand classifier: flags exponent-zero values and produces the sign-flipped operand.
module fp_classify
  import fpacc_pkg::*;
(
  input  logic [FP_W-1:0] data_i,
  output logic            is_zero_class_o,
  output logic [FP_W-1:0] neg_o
);

  assign is_zero_class_o = is_zero_class(data_i);
  assign neg_o           = {~data_i[FP_W-1], data_i[FP_W-2:0]};

endmodule

// File: rtl/fp_accum_ctrl.sv
// Frame accumulator around add_sub: sums a valid/ready operand stream, one result per in_last.
// Build option FPACC_SATURATE_EN clamps overflowed sums to the largest finite magnitude.
module fp_accum_ctrl
  import fpacc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic [CNT_W-1:0] out_count
);

  state_e           state_q, state_d;
  acc_s             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             in_ready_q, out_valid_q;

  logic             accept;
  logic             op_zero;
  logic             acc_zero;
  logic [FP_W-1:0]  op_neg;
  logic [FP_W-1:0]  eff;
  logic [FP_W-1:0]  as_result;
  logic [FP_W-1:0]  upd_sum;
  logic             as_ovf;
  logic             as_udf;

  fp_classify u_classify (
    .data_i          (in_data),
    .is_zero_class_o (op_zero),
    .neg_o           (op_neg)
  );

  add_sub u_add_sub (
    .A             (acc_q.sum),
    .B             (in_data),
    .checkequation (in_sub),
    .result        (as_result),
    .overflow      (as_ovf),
    .underflow     (as_udf)
  );

  assign accept   = in_valid && in_ready_q;
  assign eff      = in_sub ? op_neg : in_data;
  assign acc_zero = is_zero_class(acc_q.sum);
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef FPACC_SATURATE_EN
  assign upd_sum = as_ovf ? {as_result[FP_W-1], FP_MAX_FINITE_MAG} : as_result;
`else
  assign upd_sum = as_result;
`endif

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = '{sum: eff, overflow: 1'b0, underflow: 1'b0};
          cnt_d   = CNT_W'(1);
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (!op_zero) begin
            if (acc_zero) begin
              acc_d.sum = eff;
            end else begin
              acc_d.sum       = upd_sum;
              acc_d.overflow  = acc_q.overflow | as_ovf;
              acc_d.underflow = acc_q.underflow | as_udf;
            end
          end
          cnt_d = cnt_inc;
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d != DONE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_sum       = acc_q.sum;
  assign out_overflow  = acc_q.overflow;
  assign out_underflow = acc_q.underflow;
  assign out_count     = cnt_q;

endmodule
